// File: rtl/if_pkg.sv
// Shared types for the instruction fetch stage: FSM encoding, PC step and
// the fetch-queue entry layout.
package if_pkg;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    FETCH      = 2'd1,
    FLUSH_WAIT = 2'd2
  } if_state_e;

  localparam int          IF_NB_DATA = 32;
  localparam int          IF_NB_ADDR = 32;
  localparam int unsigned PC_INC     = 4;

  typedef struct packed {
    logic [IF_NB_DATA-1:0] instr;
    logic [IF_NB_ADDR-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched words; clear wins over push and the
// head entry is read straight out of the storage registers.
module fetch_queue #(
  parameter int               WIDTH     = 64,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is reset too so the head outputs have defined values after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: PC, credit-limited request/grant issue to instruction
// memory, in-order response queue and valid/ready delivery to decode.
module instr_fetch_unit import if_pkg::*; #(
  parameter int                 NB_DATA     = 32,
  parameter int                 NB_ADDR     = 32,
  parameter logic [NB_ADDR-1:0] RESET_PC    = '0,
  parameter int                 QUEUE_DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_redirect,
  input  logic [NB_ADDR-1:0] i_redirect_pc,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_instr,
  output logic [NB_ADDR-1:0] o_pc,
  output logic [NB_ADDR-1:0] o_pc_plus4,
  output logic               o_imem_req,
  output logic [NB_ADDR-1:0] o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [NB_DATA-1:0] i_imem_rdata
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  if_state_e          state, state_next;
  logic [NB_ADDR-1:0] fetch_pc, fetch_pc_next;
  logic [NB_ADDR-1:0] resp_pc, resp_pc_next;
  logic [CW-1:0]      outstanding, outstanding_next;
  logic [CW-1:0]      discard, discard_next;
  logic [CW-1:0]      q_count;
  logic [CW:0]        in_flight;
  logic [NB_ADDR-1:0] target_pc;
  logic               req_fire;
  logic               q_push, q_pop, q_full, q_empty;
  fq_entry_t          q_wdata, q_rdata;

  // Credits use registered counts only, so a pop frees its slot a cycle later.
  assign in_flight   = (CW+1)'(q_count) + (CW+1)'(outstanding);
  assign o_imem_req  = (state == FETCH) && (in_flight < (CW+1)'(QUEUE_DEPTH));
  assign o_imem_addr = fetch_pc;
  assign req_fire    = o_imem_req && i_imem_gnt;
  assign target_pc   = i_redirect_pc & ~NB_ADDR'(3);

  assign q_push  = i_imem_rvalid && (state == FETCH) && !i_redirect;
  assign q_pop   = !q_empty && i_ready;
  assign q_wdata = '{instr: i_imem_rdata, pc: resp_pc};

  fetch_queue #(
    .WIDTH     ($bits(fq_entry_t)),
    .DEPTH     (QUEUE_DEPTH),
    .RESET_VAL ({{NB_DATA{1'b0}}, RESET_PC})
  ) u_fetch_queue (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (q_push),
    .pop   (q_pop),
    .clear (i_redirect),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign o_valid    = !q_empty;
  assign o_instr    = q_rdata.instr;
  assign o_pc       = q_rdata.pc;
  assign o_pc_plus4 = q_rdata.pc + NB_ADDR'(PC_INC);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      resp_pc     <= resp_pc_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
    end
  end

  // On redirect every request still in flight after this cycle must be
  // dropped, which is exactly the next outstanding count.
  always_comb begin
    state_next       = state;
    fetch_pc_next    = fetch_pc;
    resp_pc_next     = resp_pc;
    discard_next     = discard;
    outstanding_next = outstanding + CW'(req_fire) - CW'(i_imem_rvalid);
    case (state)
      BOOT: begin
        state_next = FETCH;
        if (i_redirect) begin
          fetch_pc_next = target_pc;
          resp_pc_next  = target_pc;
        end
      end
      FETCH, FLUSH_WAIT: begin
        if ((state == FLUSH_WAIT) && i_imem_rvalid && (discard != '0))
          discard_next = discard - CW'(1);
        if (req_fire) fetch_pc_next = fetch_pc + NB_ADDR'(PC_INC);
        if (q_push)   resp_pc_next  = resp_pc + NB_ADDR'(PC_INC);
        if (i_redirect) begin
          fetch_pc_next = target_pc;
          resp_pc_next  = target_pc;
          discard_next  = outstanding_next;
        end
        state_next = (discard_next != '0) ? FLUSH_WAIT : FETCH;
      end
      default: state_next = BOOT;
    endcase
  end

  assert property (@(posedge i_clk) disable iff (i_reset)
    !(i_imem_rvalid && (outstanding == '0)));

  assert property (@(posedge i_clk) disable iff (i_reset)
    !(q_push && q_full));

endmodule
